pll_rst_sequencer: RTL and testbench
====================================

# pll_rst_sequencer

Qualifies a raw PLL lock indication and produces `NUM_CH` sequenced, lock-gated downstream resets plus per-channel clock-enable strobes. Runs in the PLL output clock domain between the PLL wrapper and the compute, SRAM and VGA datapaths. It replaces the single `locked` wire with a debounced lock, a staggered reset release, programmable rate enables and a lock-loss counter.

## Interface
- `NUM_CH`, 4: number of downstream channels; minimum 1.
- `DIV_W`, 8: width of each channel divide ratio.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-high cycles required before release; minimum 1.
- `STAGGER_CYCLES`, 16: cycles between successive channel reset releases; minimum 1.
- `SYNC_STAGES`, 2: depth of the `pll_locked` synchroniser; minimum 2.
- `LOSS_CNT_W`, 8: width of the lock-loss counter.
- `clk`  in  1  single clock, the PLL output clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  raw PLL lock; asynchronous to `clk`.
- `div_ratio`  in  NUM_CH*DIV_W  channel i occupies bits [i*DIV_W +: DIV_W]; quasi-static.
- `clear_loss`  in  1  synchronous pulse that clears `loss_count`.
- `ch_rst_n`  out  NUM_CH  per-channel active-low reset; all bits registered.
- `ce_out`  out  NUM_CH  per-channel one-cycle clock-enable strobe.
- `locked`  out  1  high while all channels are released (state RUN).
- `loss_count`  out  LOSS_CNT_W  saturating count of lock losses after release began.

## Operation
- Reset values: `ch_rst_n`=0, `ce_out`=0, `locked`=0, `loss_count`=0, state IDLE, synchroniser flops 0.
- `pll_locked` passes through a `SYNC_STAGES` flop chain and becomes `lk`.
- **IDLE**: when `lk`=1, go to STABLE with `stable_cnt`=0.
- **STABLE**: `stable_cnt` increments each cycle.
  - When `lk`=1 and `stable_cnt`==`LOCK_STABLE_CYCLES`-1, go to RELEASE.
  - On entry to RELEASE: latch `div_ratio` into shadow registers, set `ch_rst_n[0]`=1, clear `stag_cnt` and `ch_idx`.
- **RELEASE**: `stag_cnt` counts 0..`STAGGER_CYCLES`-1.
  - At wrap, release the next channel: ascending order, one channel per wrap.
  - On the cycle `ch_rst_n[NUM_CH-1]` rises, `locked` rises and the state becomes RUN.
  - With `NUM_CH`=1, `locked` rises on the STABLE→RELEASE edge.
- **RUN**: hold all outputs.
- **Lock loss**: `lk`=0 in STABLE, RELEASE or RUN.
  - Next edge: state IDLE, all `ch_rst_n`=0, `locked`=0, `ce_out`=0.
  - `loss_count` increments only if the loss occurs in RELEASE or RUN. It saturates at all-ones.
- **`clear_loss`**: if asserted in the same cycle as a counted loss, the result is 1. Otherwise the result is 0.
- **Clock-enable dividers**, one per channel, with shadow ratio D; D=0 is treated as 1.
  - Counter is held at 0 while `ch_rst_n[i]`=0.
  - Otherwise it counts 0..D-1; `ce_out[i]`=1 when the counter is D-1, then it wraps to 0.
  - D=1 gives `ce_out[i]` high every cycle after release.
- Changes to `div_ratio` after RELEASE entry are ignored until the next release sequence.

## Timing
- Latency from the first edge that samples `pll_locked` high to `ch_rst_n[0]` rising is `SYNC_STAGES`+`LOCK_STABLE_CYCLES` cycles.
- `ch_rst_n[i]` rises `i`*`STAGGER_CYCLES` cycles after `ch_rst_n[0]`.
- Lock-loss response is `SYNC_STAGES`+1 cycles from `pll_locked` falling to `ch_rst_n` all low.
- First `ce_out[i]` occurs D cycles after `ch_rst_n[i]` rises; period is D thereafter.
- All outputs are registered; there is no combinational input-to-output path.
- `rst_n` is asserted asynchronously at any point. Deassertion reaches the outputs only through the FSM path, starting in IDLE.

## Structure
- Package `pll_rst_pkg`: state enum (IDLE, STABLE, RELEASE, RUN) and width helper functions for the `$clog2` of `LOCK_STABLE_CYCLES`, `STAGGER_CYCLES` and `NUM_CH`.
- Sub-module `ce_divider` (ports `clk`, `rst_n`, `en`, `ratio`, `ce`), instantiated `NUM_CH` times in a generate loop.
- Synchroniser, FSM and loss counter are in the top level.

## Test plan
All scenarios use `NUM_CH`=3, `LOCK_STABLE_CYCLES`=8, `STAGGER_CYCLES`=4, `SYNC_STAGES`=2, ratios {1,3,0}.
- **Clean lock**: raise `pll_locked` before edge 0 → `ch_rst_n[0]` rises at edge 10, `[1]` at 14, `[2]` and `locked` at 18.
  - `ce_out[0]` is high every cycle from edge 11.
  - `ce_out[1]` is high every 3rd cycle starting at edge 17.
  - `ce_out[2]` behaves as D=1.
- **Glitchy lock**: drop `pll_locked` for 1 cycle during STABLE → return to IDLE; `loss_count` stays 0; release is re-timed from the next rising edge.
- **Loss in RUN**: drop `pll_locked` after `locked` → `ch_rst_n`=000 and `locked`=0 three cycles later; `loss_count`=1; the full sequence repeats on relock.
- **Mid-release loss**: drop `pll_locked` after `ch_rst_n[0]` has risen but before `ch_rst_n[1]` → all resets low; `loss_count` increments.
- **Saturation and clear**: with `LOSS_CNT_W`=2, force 5 losses → `loss_count`=3.
  - `clear_loss` alone → 0.
  - `clear_loss` coincident with a loss → 1.
- **Async reset and ratio change**: assert `rst_n` low in RUN → all outputs reach reset values immediately. Change `div_ratio` during RUN → `ce_out` period is unchanged.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types and width helpers for the PLL reset sequencer.
package pll_rst_pkg;

  // Sequencer states: wait for lock, qualify it, stagger releases, steady.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } pll_state_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the lock qualification counter.
  function automatic int stable_cnt_width(input int lock_stable_cycles);
    return cnt_width(lock_stable_cycles);
  endfunction

  // Width of the inter-channel stagger counter.
  function automatic int stag_cnt_width(input int stagger_cycles);
    return cnt_width(stagger_cycles);
  endfunction

  // Width of the channel index.
  function automatic int ch_idx_width(input int num_ch);
    return cnt_width(num_ch);
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Per-channel clock-enable divider: one-cycle strobe every `ratio` cycles
// while enabled; a ratio of zero behaves as one.
module ce_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] ratio,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last;
  logic             ce_q, ce_d;

  // Terminal count of the divider, folding ratio 0 onto ratio 1.
  always_comb begin
    last = (ratio == '0) ? '0 : ratio - DIV_W'(1);
  end

  // Count 0..last while enabled, strobe on the terminal count, hold at 0 otherwise.
  always_comb begin
    cnt_d = '0;
    ce_d  = 1'b0;
    if (en) begin
      if (cnt_q == last) begin
        cnt_d = '0;
        ce_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Divider state and registered strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL lock qualifier and staggered reset sequencer. Synchronises the raw
// lock, waits for it to be stable, releases channel resets one by one,
// drives per-channel clock enables and counts lock losses after release.
module pll_rst_sequencer
  import pll_rst_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int DIV_W              = 8,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic                    clear_loss,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    locked,
  output logic [LOSS_CNT_W-1:0]   loss_count
);

  localparam int STB_W = stable_cnt_width(LOCK_STABLE_CYCLES);
  localparam int STG_W = stag_cnt_width(STAGGER_CYCLES);
  localparam int IDX_W = ch_idx_width(NUM_CH);

  localparam logic [STB_W-1:0]      STABLE_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STG_W-1:0]      STAG_LAST   = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]      CH_LAST     = IDX_W'(NUM_CH - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = '1;

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    lk;
  pll_state_e              state_q, state_d;
  logic [STB_W-1:0]        stable_cnt_q, stable_cnt_d;
  logic [STG_W-1:0]        stag_cnt_q, stag_cnt_d;
  logic [IDX_W-1:0]        ch_idx_q, ch_idx_d;
  logic [IDX_W-1:0]        next_idx;
  logic [NUM_CH-1:0]       ch_rst_n_q, ch_rst_n_d;
  logic                    locked_q, locked_d;
  logic [NUM_CH*DIV_W-1:0] shadow_q, shadow_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    lost;
  logic                    counted;

  // Lock drops anywhere past IDLE abort the sequence; only losses after
  // release began are counted.
  assign lk       = sync_q[SYNC_STAGES-1];
  assign lost     = ~lk & (state_q != IDLE);
  assign counted  = ~lk & ((state_q == RELEASE) | (state_q == RUN));
  assign next_idx = ch_idx_q + IDX_W'(1);

  // Shift the raw lock into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  // Synchroniser flops for the asynchronous lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: qualify lock, stagger releases, fall back to IDLE on loss.
  always_comb begin
    state_d = state_q;
    if (lost) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (lk) state_d = STABLE;
        STABLE:  if (stable_cnt_q == STABLE_LAST) state_d = (NUM_CH == 1) ? RUN : RELEASE;
        RELEASE: if ((stag_cnt_q == STAG_LAST) && (next_idx == CH_LAST)) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs and counters: next values of resets, locked, shadows and counters.
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    stag_cnt_d   = stag_cnt_q;
    ch_idx_d     = ch_idx_q;
    ch_rst_n_d   = ch_rst_n_q;
    locked_d     = locked_q;
    shadow_d     = shadow_q;
    if (lost) begin
      stable_cnt_d = '0;
      stag_cnt_d   = '0;
      ch_idx_d     = '0;
      ch_rst_n_d   = '0;
      locked_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stable_cnt_d = '0;
        end
        STABLE: begin
          if (stable_cnt_q == STABLE_LAST) begin
            shadow_d   = div_ratio;
            ch_rst_n_d = NUM_CH'(1);
            stag_cnt_d = '0;
            ch_idx_d   = '0;
            locked_d   = (NUM_CH == 1);
          end else begin
            stable_cnt_d = stable_cnt_q + STB_W'(1);
          end
        end
        RELEASE: begin
          if (stag_cnt_q == STAG_LAST) begin
            stag_cnt_d = '0;
            ch_idx_d   = next_idx;
            ch_rst_n_d = ch_rst_n_q | (NUM_CH'(1) << next_idx);
            locked_d   = (next_idx == CH_LAST);
          end else begin
            stag_cnt_d = stag_cnt_q + STG_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Saturating lock-loss counter; a clear coinciding with a loss leaves one.
  always_comb begin
    loss_d = loss_q;
    if (clear_loss) begin
      loss_d = counted ? LOSS_CNT_W'(1) : '0;
    end else if (counted && (loss_q != LOSS_MAX)) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  // Datapath registers: counters, resets, locked flag, ratio shadows, loss count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt_q <= '0;
      stag_cnt_q   <= '0;
      ch_idx_q     <= '0;
      ch_rst_n_q   <= '0;
      locked_q     <= 1'b0;
      shadow_q     <= '0;
      loss_q       <= '0;
    end else begin
      stable_cnt_q <= stable_cnt_d;
      stag_cnt_q   <= stag_cnt_d;
      ch_idx_q     <= ch_idx_d;
      ch_rst_n_q   <= ch_rst_n_d;
      locked_q     <= locked_d;
      shadow_q     <= shadow_d;
      loss_q       <= loss_d;
    end
  end

  // Enable requires the channel released now and staying released, so the
  // first strobe lands one full period after release and a lock loss
  // silences the strobe on the same edge the reset drops.
  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    ce_divider #(
      .DIV_W (DIV_W)
    ) u_ce_divider (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ch_rst_n_d[i] & ch_rst_n_q[i]),
      .ratio (shadow_q[i*DIV_W +: DIV_W]),
      .ce    (ce_out[i])
    );
  end

  assign ch_rst_n   = ch_rst_n_q;
  assign locked     = locked_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Self-checking bench for pll_rst_sequencer: directed scenarios plus a
// randomized lock/loss phase, checked every cycle against a timeline model.
module tb_pll_rst_sequencer;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int LSC    = 8;
  localparam int STAG   = 4;
  localparam int SYNC   = 2;
  localparam int LW     = 2;
  localparam int REL0   = LSC + 1;              // model step count at ch 0 release
  localparam int EW     = 1 + LW + 2 * NUM_CH;

  // ---------------- clock / reset ----------------
  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic pll_locked = 1'b0;
  logic clear_loss = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_ratio = '0;
  logic [NUM_CH-1:0]       ch_rst_n;
  logic [NUM_CH-1:0]       ce_out;
  logic                    locked;
  logic [LW-1:0]           loss_count;

  always #5 clk = ~clk;

  pll_rst_sequencer #(
    .NUM_CH             (NUM_CH),
    .DIV_W              (DIV_W),
    .LOCK_STABLE_CYCLES (LSC),
    .STAGGER_CYCLES     (STAG),
    .SYNC_STAGES        (SYNC),
    .LOSS_CNT_W         (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .div_ratio  (div_ratio),
    .clear_loss (clear_loss),
    .ch_rst_n   (ch_rst_n),
    .ce_out     (ce_out),
    .locked     (locked),
    .loss_count (loss_count)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. m_p counts consecutive clock edges at which the
  // synchronised lock was high; every output is a function of that count:
  // channel i is released once m_p reaches REL0 + i*STAG, and its strobe
  // fires every D edges after its release.
  logic [SYNC-1:0] m_pipe = '0;
  int m_p    = 0;
  int m_loss = 0;
  int m_div[NUM_CH];

  task automatic model_step();
    logic              lk_m;
    bit                cnt_loss;
    int                q;
    int                d;
    logic [NUM_CH-1:0] e_rst;
    logic [NUM_CH-1:0] e_ce;
    logic              e_lock;
    if (!rst_n) begin
      m_pipe = '0;
      m_p    = 0;
      m_loss = 0;
      exp_q.delete();
      exp_q.push_back('0);
      return;
    end
    lk_m     = m_pipe[SYNC-1];
    m_pipe   = {m_pipe[SYNC-2:0], pll_locked};
    cnt_loss = !lk_m && (m_p >= REL0);
    m_p      = lk_m ? m_p + 1 : 0;
    if (m_p == REL0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        d = int'(div_ratio[i*DIV_W +: DIV_W]);
        m_div[i] = (d == 0) ? 1 : d;
      end
    end
    if (clear_loss) m_loss = cnt_loss ? 1 : 0;
    else if (cnt_loss && m_loss < (1 << LW) - 1) m_loss++;
    for (int i = 0; i < NUM_CH; i++) begin
      q = m_p - (REL0 + i * STAG);
      e_rst[i] = (m_p > 0) && (q >= 0);
      e_ce[i]  = (m_p > 0) && (q >= 1) && ((q % m_div[i]) == 0);
    end
    e_lock = (m_p > 0) && (m_p >= REL0 + (NUM_CH - 1) * STAG);
    exp_q.push_back({e_lock, LW'(m_loss), e_ce, e_rst});
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) m_div[i] = 1;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Per-cycle comparison of DUT outputs against the model, away from the edge.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cyc_ch_rst_n",   32'(ch_rst_n),   32'(e[NUM_CH-1:0]));
        chk("cyc_ce_out",     32'(ce_out),     32'(e[2*NUM_CH-1:NUM_CH]));
        chk("cyc_loss_count", 32'(loss_count), 32'(e[2*NUM_CH+LW-1:2*NUM_CH]));
        chk("cyc_locked",     32'(locked),     32'(e[EW-1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ratios(input int r0, input int r1, input int r2);
    div_ratio = {DIV_W'(r2), DIV_W'(r1), DIV_W'(r0)};
  endtask

  // Edge indices (from the first edge sampling the lock high) of each release and first strobe.
  task automatic measure_seq(output int r0, output int r1, output int r2, output int rl,
                             output int c0, output int c1, output int c2);
    r0 = -1; r1 = -1; r2 = -1; rl = -1; c0 = -1; c1 = -1; c2 = -1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (ch_rst_n[0] && r0 < 0) r0 = e;
      if (ch_rst_n[1] && r1 < 0) r1 = e;
      if (ch_rst_n[2] && r2 < 0) r2 = e;
      if (locked && rl < 0)      rl = e;
      if (ce_out[0] && c0 < 0)   c0 = e;
      if (ce_out[1] && c1 < 0)   c1 = e;
      if (ce_out[2] && c2 < 0)   c2 = e;
    end
    @(negedge clk);
  endtask

  task automatic lock_and_run();
    bit seen;
    seen = 1'b0;
    pll_locked = 1'b1;
    for (int e = 0; e < 100 && !seen; e++) begin
      @(posedge clk);
      #1;
      if (locked) seen = 1'b1;
    end
    chk("lock_timeout", 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic drop_lock();
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0, r1, r2, rl, c0, c1, c2;
    int n;
    int hold;

    set_ratios(1, 3, 0);
    repeat (3) @(negedge clk);
    chk("rst_ch_rst_n",   32'(ch_rst_n),   32'd0);
    chk("rst_ce_out",     32'(ce_out),     32'd0);
    chk("rst_locked",     32'(locked),     32'd0);
    chk("rst_loss_count", 32'(loss_count), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean lock
    pll_locked = 1'b1;
    measure_seq(r0, r1, r2, rl, c0, c1, c2);
    chk("clean_rise0",   32'(r0), 32'd10);
    chk("clean_rise1",   32'(r1), 32'd14);
    chk("clean_rise2",   32'(r2), 32'd18);
    chk("clean_locked",  32'(rl), 32'd18);
    chk("clean_ce0",     32'(c0), 32'd11);
    chk("clean_ce1",     32'(c1), 32'd17);
    chk("clean_ce2",     32'(c2), 32'd19);

    // Ratio change during RUN must not disturb the strobe periods
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      set_ratios($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
    end

    // Loss in RUN
    pll_locked = 1'b0;
    n = -1;
    for (int e = 0; e < 20 && n < 0; e++) begin
      @(posedge clk);
      #1;
      if (ch_rst_n == '0 && !locked) n = e;
    end
    chk("loss_resp_edge", 32'(n), 32'(SYNC));
    @(negedge clk);
    chk("loss_run_count", 32'(loss_count), 32'd1);
    repeat (3) @(negedge clk);

    // Relock repeats the full sequence
    set_ratios(1, 3, 0);
    pll_locked = 1'b1;
    measure_seq(r0, r1, r2, rl, c0, c1, c2);
    chk("relock_rise0",  32'(r0), 32'd10);
    chk("relock_locked", 32'(rl), 32'd18);
    drop_lock();
    repeat (2) @(negedge clk);
    chk("relock_loss_count", 32'(loss_count), 32'd2);

    // Glitchy lock: one low cycle in STABLE, release re-timed, no count
    pll_locked = 1'b1;
    repeat (5) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    measure_seq(r0, r1, r2, rl, c0, c1, c2);
    chk("glitch_rise0",  32'(r0), 32'd10);
    chk("glitch_rise2",  32'(r2), 32'd18);
    chk("glitch_ce1",    32'(c1), 32'd17);
    drop_lock();
    @(negedge clk);
    chk("glitch_then_run_loss", 32'(loss_count), 32'd3);

    // Clear alone
    clear_loss = 1'b1;
    @(negedge clk);
    clear_loss = 1'b0;
    chk("clear_alone", 32'(loss_count), 32'd0);

    // Mid-release loss
    pll_locked = 1'b1;
    n = -1;
    for (int e = 0; e < 40 && n < 0; e++) begin
      @(posedge clk);
      #1;
      if (ch_rst_n[0]) n = e;
    end
    chk("midrel_rise0", 32'(n), 32'd10);
    @(negedge clk);
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrel_rst",   32'(ch_rst_n),   32'd0);
    chk("midrel_count", 32'(loss_count), 32'd1);

    // Saturation: four more losses push the 2-bit counter to all-ones
    for (int k = 0; k < 4; k++) begin
      lock_and_run();
      drop_lock();
    end
    chk("sat_count", 32'(loss_count), 32'd3);

    // Clear coincident with a counted loss
    lock_and_run();
    pll_locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_loss = 1'b1;
    @(negedge clk);
    clear_loss = 1'b0;
    chk("clear_with_loss", 32'(loss_count), 32'd1);
    repeat (3) @(negedge clk);

    // Asynchronous reset in RUN
    lock_and_run();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ch_rst_n",   32'(ch_rst_n),   32'd0);
    chk("arst_ce_out",     32'(ce_out),     32'd0);
    chk("arst_locked",     32'(locked),     32'd0);
    chk("arst_loss_count", 32'(loss_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized lock/loss/clear/ratio traffic
    hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (hold == 0) begin
        pll_locked = ~pll_locked;
        hold = pll_locked ? $urandom_range(1, 45) : $urandom_range(1, 5);
      end else begin
        hold--;
      end
      clear_loss = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        set_ratios($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
    end
    clear_loss = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
